// File: rtl/wavegen_frame_loader.sv
// Assembles 41-byte wavegen channel records from the control-link byte stream and
// publishes each record to the channel bank in one strobe once its XOR checksum passes.
module wavegen_frame_loader #(
    parameter int NUM_CHANNELS = 16,
    parameter int TIMEOUT      = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             wr_en,
    output logic [4:0]       wr_channel,
    output logic [31:0]      freq,
    output logic [7:0]       velocity,
    output logic [7:0]       shape,
    output logic [7:0]       cmds,
    output logic [7:0][15:0] env_gain,
    output logic [7:0][15:0] env_duration,
    output logic             frame_err
);

    localparam int LAST_PAYLOAD = 39;
    localparam int TW           = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, PAYLOAD, CHECK, COMMIT, ERROR} state_t;

    state_t          state_q;
    logic [5:0]      idx_q;
    logic [7:0]      xor_q;
    logic [TW-1:0]   idle_q;
    logic [4:0]      stage_ch_q;
    logic [7:0]      stage_q [1:LAST_PAYLOAD];

    logic [31:0]       stage_freq;
    logic [7:0][15:0]  stage_gain;
    logic [7:0][15:0]  stage_dur;
    logic              ch_ok;

    // Byte offsets inside the frame: 1..4 freq, 5 velocity, 6 shape, 7 cmds,
    // then four bytes per envelope segment (gain MSB/LSB, duration MSB/LSB).
    assign stage_freq = {stage_q[1], stage_q[2], stage_q[3], stage_q[4]};
    for (genvar gi = 0; gi < 8; gi++) begin : g_seg
        assign stage_gain[gi] = {stage_q[8 + 4*gi], stage_q[9 + 4*gi]};
        assign stage_dur[gi]  = {stage_q[10 + 4*gi], stage_q[11 + 4*gi]};
    end

    assign ch_ok = 32'(stage_ch_q) < 32'(NUM_CHANNELS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            xor_q        <= '0;
            idle_q       <= '0;
            stage_ch_q   <= '0;
            wr_en        <= 1'b0;
            frame_err    <= 1'b0;
            wr_channel   <= '0;
            freq         <= '0;
            velocity     <= '0;
            shape        <= '0;
            cmds         <= '0;
            env_gain     <= '0;
            env_duration <= '0;
        end else begin
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            // COMMIT and ERROR last one cycle and behave like IDLE so streaming loses nothing.
            if (frame_start || state_q == IDLE || state_q == COMMIT || state_q == ERROR) begin
                idle_q <= '0;
                if (byte_valid) begin
                    stage_ch_q <= byte_data[4:0];
                    xor_q      <= byte_data;
                    idx_q      <= 6'd1;
                    state_q    <= PAYLOAD;
                end else begin
                    state_q <= IDLE;
                end
            end else if (byte_valid) begin
                idle_q <= '0;
                xor_q  <= xor_q ^ byte_data;
                if (state_q == PAYLOAD) begin
                    stage_q[idx_q] <= byte_data;
                    idx_q          <= idx_q + 6'd1;
                    if (idx_q == 6'(LAST_PAYLOAD)) begin
                        state_q <= CHECK;
                    end
                end else if (byte_data == xor_q && ch_ok) begin
                    state_q      <= COMMIT;
                    wr_en        <= 1'b1;
                    wr_channel   <= stage_ch_q;
                    freq         <= stage_freq;
                    velocity     <= stage_q[5];
                    shape        <= stage_q[6];
                    cmds         <= stage_q[7];
                    env_gain     <= stage_gain;
                    env_duration <= stage_dur;
                end else begin
                    state_q   <= ERROR;
                    frame_err <= 1'b1;
                end
            end else if (idle_q == TW'(TIMEOUT - 1)) begin
                state_q   <= ERROR;
                frame_err <= 1'b1;
            end else begin
                idle_q <= idle_q + TW'(1);
            end
        end
    end

endmodule
